// File: rtl/pzcorebus_buffered_downsizer_request_path_pkg.sv
// Shared types for the downsizer request path: command encoding,
// command classification helpers and the write-data FSM states.
package pzcorebus_buffered_downsizer_request_path_pkg;

    typedef enum logic [2:0] {
        PZCOREBUS_NULL               = 3'b000,
        PZCOREBUS_MESSAGE            = 3'b001,
        PZCOREBUS_MESSAGE_NON_POSTED = 3'b011,
        PZCOREBUS_READ               = 3'b100,
        PZCOREBUS_WRITE              = 3'b101,
        PZCOREBUS_ATOMIC             = 3'b110,
        PZCOREBUS_WRITE_NON_POSTED   = 3'b111
    } pzcorebus_command_type;

    typedef enum logic [1:0] {
        CMD_KIND_NO_DATA,
        CMD_KIND_DATA,
        CMD_KIND_DATA_NO_OFFSET
    } pzcorebus_command_kind;

    typedef enum logic {
        DATA_IDLE,
        DATA_BURST
    } data_state_t;

    function automatic pzcorebus_command_kind get_command_kind(
        pzcorebus_command_type cmd
    );
        pzcorebus_command_kind kind;
        unique case (1'b1)
            (cmd inside {PZCOREBUS_WRITE, PZCOREBUS_WRITE_NON_POSTED}):
                kind = CMD_KIND_DATA;
            (cmd inside {PZCOREBUS_ATOMIC, PZCOREBUS_MESSAGE_NON_POSTED}):
                kind = CMD_KIND_DATA_NO_OFFSET;
            default:
                kind = CMD_KIND_NO_DATA;
        endcase
        return kind;
    endfunction

    function automatic logic is_command_with_data(
        pzcorebus_command_type cmd
    );
        return get_command_kind(cmd) != CMD_KIND_NO_DATA;
    endfunction

    // Atomics and messages carry their payload from unit 0 of the bus.
    function automatic logic is_no_offset_command(
        pzcorebus_command_type cmd
    );
        return get_command_kind(cmd) == CMD_KIND_DATA_NO_OFFSET;
    endfunction

endpackage

// File: rtl/pzcorebus_buffered_downsizer_request_path_if.sv
// Corebus request-side bundle: command channel plus write-data channel.
// The master drives command/data, the slave answers with accepts.
interface pzcorebus_buffered_downsizer_request_path_if #(
    parameter int DATA_WIDTH    = 64,
    parameter int ADDRESS_WIDTH = 64,
    parameter int LENGTH_WIDTH  = 8
) ();
    import pzcorebus_buffered_downsizer_request_path_pkg::*;

    logic                      mcmd_valid;
    logic                      scmd_accept;
    pzcorebus_command_type     mcmd;
    logic [ADDRESS_WIDTH-1:0]  maddr;
    logic [LENGTH_WIDTH-1:0]   mlength;
    logic                      mdata_valid;
    logic                      sdata_accept;
    logic [DATA_WIDTH-1:0]     mdata;
    logic [DATA_WIDTH/8-1:0]   mdata_byteen;
    logic                      mdata_last;

    modport master (
        output mcmd_valid,
        output mcmd,
        output maddr,
        output mlength,
        input  scmd_accept,
        output mdata_valid,
        output mdata,
        output mdata_byteen,
        output mdata_last,
        input  sdata_accept
    );

    modport slave (
        input  mcmd_valid,
        input  mcmd,
        input  maddr,
        input  mlength,
        output scmd_accept,
        input  mdata_valid,
        input  mdata,
        input  mdata_byteen,
        input  mdata_last,
        output sdata_accept
    );

endinterface

// File: rtl/pzcorebus_buffered_downsizer_request_path_cmd_fifo.sv
// Small command-info FIFO with registered empty/full flags and
// unregistered head read.
module pzcorebus_buffered_downsizer_request_path_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full
);
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0]   LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [CNTW-1:0]  count;
    logic [CNTW-1:0]  count_next;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] next_ptr(logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    assign do_push = i_push & !o_full;
    assign do_pop  = i_pop & !o_empty;
    assign o_data  = mem[rptr];

    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + CNTW'(1);
            2'b01:   count_next = count - CNTW'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            o_empty <= 1'b1;
            o_full  <= 1'b0;
        end else begin
            if (do_push) begin
                wptr <= next_ptr(wptr);
            end
            if (do_pop) begin
                rptr <= next_ptr(rptr);
            end
            count   <= count_next;
            o_empty <= count_next == '0;
            o_full  <= count_next == FULL_CNT;
        end
    end

endmodule

// File: rtl/pzcorebus_buffered_downsizer_request_path.sv
// Request path of the corebus downsizer: splits wide write beats into
// narrow ones, queuing per-command offset/length until data arrives.
module pzcorebus_buffered_downsizer_request_path
    import pzcorebus_buffered_downsizer_request_path_pkg::*;
#(
    parameter int SLAVE_DATA_WIDTH    = 256,
    parameter int MASTER_DATA_WIDTH   = 64,
    parameter int UNIT_DATA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH       = 64,
    parameter int LENGTH_WIDTH        = 8,
    parameter int CMD_FIFO_DEPTH      = 4,
    parameter bit ALIGNED_ACCESS_ONLY = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    pzcorebus_buffered_downsizer_request_path_if.slave  slave_if,
    pzcorebus_buffered_downsizer_request_path_if.master master_if,
    output logic o_protocol_error
);
    localparam int RATIO     = SLAVE_DATA_WIDTH / MASTER_DATA_WIDTH;
    localparam int DATA_SIZE = MASTER_DATA_WIDTH / UNIT_DATA_WIDTH;
    localparam int CW        = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int MLSB      = $clog2(MASTER_DATA_WIDTH) - 3;
    localparam int ULSB      = $clog2(UNIT_DATA_WIDTH) - 3;
    localparam int OW        = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
    localparam int LEN_W     = LENGTH_WIDTH + 1;
    localparam int FIFO_W    = LEN_W + CW;

    localparam logic [LEN_W-1:0] DS_LEN   = LEN_W'(DATA_SIZE);
    localparam logic [CW-1:0]    LAST_CNT = CW'(RATIO - 1);

    pzcorebus_command_type    cmd;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic                     with_data;
    logic                     no_off;
    logic                     cmd_block;
    logic                     cmd_push_hs;

    logic [CW-1:0]     init_cnt;
    logic [OW-1:0]     init_off;
    logic [LEN_W-1:0]  init_len;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_empty;
    logic              fifo_full;
    logic [FIFO_W-1:0] fifo_head;
    logic [LEN_W-1:0]  head_len;
    logic [CW-1:0]     head_cnt;

    data_state_t       state_q;
    logic [LEN_W-1:0]  len_q;
    logic [CW-1:0]     cnt_q;

    logic              src_valid;
    logic              bypass;
    logic [LEN_W-1:0]  cur_len;
    logic [CW-1:0]     cur_cnt;
    logic [CW-1:0]     sel;
    logic              final_beat;
    logic              consume;
    logic              beat_hs;
    logic              slave_hs;

    assign cmd  = slave_if.mcmd;
    assign addr = slave_if.maddr;

    assign with_data = is_command_with_data(cmd);
    assign no_off    = ALIGNED_ACCESS_ONLY || is_no_offset_command(cmd);
    assign cmd_block = with_data & fifo_full;

    assign master_if.mcmd_valid = slave_if.mcmd_valid & !cmd_block;
    assign slave_if.scmd_accept = master_if.scmd_accept & !cmd_block;
    assign master_if.mcmd       = cmd;
    assign master_if.maddr      = addr;
    assign master_if.mlength    = slave_if.mlength;

    assign cmd_push_hs = slave_if.mcmd_valid & master_if.scmd_accept
                       & with_data & !fifo_full;

    always_comb begin
        init_cnt = '0;
        init_off = '0;
        if (!no_off && RATIO > 1) begin
            init_cnt = addr[MLSB +: CW];
        end
        if (!no_off && DATA_SIZE > 1) begin
            init_off = addr[ULSB +: OW];
        end
        init_len = LEN_W'(slave_if.mlength) + LEN_W'(init_off);
    end

    // A command whose first beat leaves on the same cycle is never queued.
    assign fifo_push = cmd_push_hs & !(bypass & beat_hs);
    assign fifo_pop  = beat_hs & (state_q == DATA_IDLE) & !bypass;

    pzcorebus_buffered_downsizer_request_path_cmd_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (CMD_FIFO_DEPTH)
    ) u_cmd_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (fifo_push),
        .i_data  ({init_len, init_cnt}),
        .i_pop   (fifo_pop),
        .o_data  (fifo_head),
        .o_empty (fifo_empty),
        .o_full  (fifo_full)
    );

    assign {head_len, head_cnt} = fifo_head;

    always_comb begin
        src_valid = 1'b0;
        bypass    = 1'b0;
        cur_len   = len_q;
        cur_cnt   = cnt_q;
        unique case (1'b1)
            (state_q == DATA_BURST): begin
                src_valid = 1'b1;
            end
            (state_q == DATA_IDLE && !fifo_empty): begin
                src_valid = 1'b1;
                cur_len   = head_len;
                cur_cnt   = head_cnt;
            end
            (state_q == DATA_IDLE && fifo_empty && cmd_push_hs): begin
                src_valid = 1'b1;
                bypass    = 1'b1;
                cur_len   = init_len;
                cur_cnt   = init_cnt;
            end
            default: begin
                src_valid = 1'b0;
            end
        endcase
    end

    assign final_beat = cur_len <= DS_LEN;
    assign consume    = final_beat | (cur_cnt == LAST_CNT);
    assign sel        = (RATIO > 1) ? cur_cnt : '0;

    assign master_if.mdata_valid  = slave_if.mdata_valid & src_valid;
    assign slave_if.sdata_accept  = master_if.sdata_accept & consume
                                  & src_valid;
    assign master_if.mdata_last   = final_beat;
    assign master_if.mdata        =
        slave_if.mdata[sel*MASTER_DATA_WIDTH +: MASTER_DATA_WIDTH];
    assign master_if.mdata_byteen =
        slave_if.mdata_byteen[sel*(MASTER_DATA_WIDTH/8) +: MASTER_DATA_WIDTH/8];

    assign beat_hs  = master_if.mdata_valid & master_if.sdata_accept;
    assign slave_hs = slave_if.mdata_valid & slave_if.sdata_accept;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q          <= DATA_IDLE;
            len_q            <= '0;
            cnt_q            <= '0;
            o_protocol_error <= 1'b0;
        end else begin
            o_protocol_error <= slave_hs
                              & (slave_if.mdata_last != final_beat);
            if (beat_hs) begin
                len_q   <= cur_len - DS_LEN;
                cnt_q   <= (RATIO > 1) ? cur_cnt + CW'(1) : '0;
                state_q <= final_beat ? DATA_IDLE : DATA_BURST;
            end
        end
    end

endmodule

// File: tb/tb_pzcorebus_buffered_downsizer_request_path.sv
// Directed bench for the downsizer request path with default widths
// (RATIO 4, DATA_SIZE 2).
module tb_pzcorebus_buffered_downsizer_request_path;
    import pzcorebus_buffered_downsizer_request_path_pkg::*;

    localparam int SDW = 256;
    localparam int MDW = 64;
    localparam int AW  = 64;
    localparam int LW  = 8;

    localparam logic [31:0] BYTEEN = 32'h8743_2110;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic prot_err;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    pzcorebus_buffered_downsizer_request_path_if #(
        .DATA_WIDTH(SDW), .ADDRESS_WIDTH(AW), .LENGTH_WIDTH(LW)
    ) s_if ();

    pzcorebus_buffered_downsizer_request_path_if #(
        .DATA_WIDTH(MDW), .ADDRESS_WIDTH(AW), .LENGTH_WIDTH(LW)
    ) m_if ();

    pzcorebus_buffered_downsizer_request_path #(
        .SLAVE_DATA_WIDTH    (SDW),
        .MASTER_DATA_WIDTH   (MDW),
        .UNIT_DATA_WIDTH     (32),
        .ADDRESS_WIDTH       (AW),
        .LENGTH_WIDTH        (LW),
        .CMD_FIFO_DEPTH      (4),
        .ALIGNED_ACCESS_ONLY (1'b0)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .slave_if         (s_if),
        .master_if        (m_if),
        .o_protocol_error (prot_err)
    );

    function automatic logic [63:0] slice(int b, int k);
        return {32'hC0DE_0000 | 32'(b), 32'h5A5A_0000 | 32'(k)};
    endfunction

    function automatic logic [255:0] wide(int b);
        logic [255:0] w;
        for (int k = 0; k < 4; k++) begin
            w[k*64 +: 64] = slice(b, k);
        end
        return w;
    endfunction

    function automatic logic [7:0] exp_be(int k);
        case (k)
            0:       return 8'h10;
            1:       return 8'h21;
            2:       return 8'h43;
            default: return 8'h87;
        endcase
    endfunction

    task automatic idle_inputs();
        s_if.mcmd_valid   = 1'b0;
        s_if.mcmd         = PZCOREBUS_NULL;
        s_if.maddr        = '0;
        s_if.mlength      = '0;
        s_if.mdata_valid  = 1'b0;
        s_if.mdata        = '0;
        s_if.mdata_byteen = '0;
        s_if.mdata_last   = 1'b0;
        m_if.scmd_accept  = 1'b1;
        m_if.sdata_accept = 1'b1;
    endtask

    task automatic set_cmd(pzcorebus_command_type c, logic [63:0] a,
                           logic [7:0] l);
        s_if.mcmd_valid = 1'b1;
        s_if.mcmd       = c;
        s_if.maddr      = a;
        s_if.mlength    = l;
    endtask

    task automatic set_data(int b, logic last);
        s_if.mdata_valid  = 1'b1;
        s_if.mdata        = wide(b);
        s_if.mdata_byteen = BYTEEN;
        s_if.mdata_last   = last;
    endtask

    task automatic test_reset();
        idle_inputs();
        s_if.mdata_valid = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (m_if.mdata_valid !== 1'b0 || s_if.sdata_accept !== 1'b0) begin
            failures++;
            $display("FAIL reset_data valid=%b accept=%b exp 0/0",
                     m_if.mdata_valid, s_if.sdata_accept);
        end
        checks++;
        if (prot_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_err got=%b exp=0", prot_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        set_cmd(PZCOREBUS_WRITE, 64'h100, 8'd4);
        m_if.scmd_accept = 1'b0;
        #1;
        checks++;
        if (m_if.mdata_valid !== 1'b0 || s_if.sdata_accept !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_source valid=%b accept=%b exp 0/0",
                     m_if.mdata_valid, s_if.sdata_accept);
        end
        checks++;
        if (m_if.mcmd_valid !== 1'b1 || s_if.scmd_accept !== 1'b0 ||
            m_if.maddr !== 64'h100 || m_if.mlength !== 8'd4 ||
            m_if.mcmd !== PZCOREBUS_WRITE) begin
            failures++;
            $display("FAIL cmd_passthru v=%b a=%b addr=%h len=%0d exp 1/0/100/4",
                     m_if.mcmd_valid, s_if.scmd_accept, m_if.maddr,
                     m_if.mlength);
        end
        idle_inputs();
    endtask

    task automatic test_bypass();
        @(negedge clk);
        set_cmd(PZCOREBUS_WRITE, 64'h28, 8'd5);
        set_data(1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                @(negedge clk);
                s_if.mcmd_valid = 1'b0;
            end
            #1;
            if (i == 0) begin
                checks++;
                if (m_if.mcmd_valid !== 1'b1 || s_if.scmd_accept !== 1'b1) begin
                    failures++;
                    $display("FAIL bypass_cmd v=%b a=%b exp 1/1",
                             m_if.mcmd_valid, s_if.scmd_accept);
                end
            end
            checks++;
            if (m_if.mdata_valid !== 1'b1 || m_if.mdata !== slice(1, i + 1) ||
                m_if.mdata_byteen !== exp_be(i + 1)) begin
                failures++;
                $display("FAIL bypass_beat%0d v=%b d=%h be=%h exp d=%h be=%h",
                         i, m_if.mdata_valid, m_if.mdata, m_if.mdata_byteen,
                         slice(1, i + 1), exp_be(i + 1));
            end
            checks++;
            if (m_if.mdata_last !== (i == 2) ||
                s_if.sdata_accept !== (i == 2)) begin
                failures++;
                $display("FAIL bypass_last%0d last=%b acc=%b exp %b",
                         i, m_if.mdata_last, s_if.sdata_accept, i == 2);
            end
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (prot_err !== 1'b0 || m_if.mdata_valid !== 1'b0) begin
            failures++;
            $display("FAIL bypass_end err=%b v=%b exp 0/0",
                     prot_err, m_if.mdata_valid);
        end
    endtask

    task automatic test_unaligned();
        int slc [5];
        slc = '{0, 1, 2, 3, 0};
        @(negedge clk);
        set_cmd(PZCOREBUS_WRITE, 64'h24, 8'd8);
        #1;
        checks++;
        if (m_if.mcmd_valid !== 1'b1 || m_if.mdata_valid !== 1'b0) begin
            failures++;
            $display("FAIL unal_cmd v=%b dv=%b exp 1/0",
                     m_if.mcmd_valid, m_if.mdata_valid);
        end
        for (int i = 0; i < 5; i++) begin
            int sb;
            sb = (i < 4) ? 0 : 1;
            @(negedge clk);
            s_if.mcmd_valid = 1'b0;
            set_data(10 + sb, sb == 1);
            #1;
            checks++;
            if (m_if.mdata_valid !== 1'b1 ||
                m_if.mdata !== slice(10 + sb, slc[i]) ||
                m_if.mdata_byteen !== exp_be(slc[i])) begin
                failures++;
                $display("FAIL unal_beat%0d v=%b d=%h exp %h",
                         i, m_if.mdata_valid, m_if.mdata,
                         slice(10 + sb, slc[i]));
            end
            checks++;
            if (s_if.sdata_accept !== (i >= 3) ||
                m_if.mdata_last !== (i == 4) || prot_err !== 1'b0) begin
                failures++;
                $display("FAIL unal_ctl%0d acc=%b last=%b err=%b exp %b/%b/0",
                         i, s_if.sdata_accept, m_if.mdata_last, prot_err,
                         i >= 3, i == 4);
            end
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (prot_err !== 1'b0 || m_if.mdata_valid !== 1'b0) begin
            failures++;
            $display("FAIL unal_end err=%b v=%b exp 0/0",
                     prot_err, m_if.mdata_valid);
        end
    endtask

    task automatic test_atomic();
        @(negedge clk);
        set_cmd(PZCOREBUS_ATOMIC, 64'h38, 8'd2);
        set_data(20, 1'b1);
        #1;
        checks++;
        if (m_if.mdata_valid !== 1'b1 || m_if.mdata !== slice(20, 0) ||
            m_if.mdata_byteen !== exp_be(0)) begin
            failures++;
            $display("FAIL atomic_data v=%b d=%h be=%h exp %h/%h",
                     m_if.mdata_valid, m_if.mdata, m_if.mdata_byteen,
                     slice(20, 0), exp_be(0));
        end
        checks++;
        if (m_if.mdata_last !== 1'b1 || s_if.sdata_accept !== 1'b1) begin
            failures++;
            $display("FAIL atomic_last last=%b acc=%b exp 1/1",
                     m_if.mdata_last, s_if.sdata_accept);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (prot_err !== 1'b0 || m_if.mdata_valid !== 1'b0) begin
            failures++;
            $display("FAIL atomic_end err=%b v=%b exp 0/0",
                     prot_err, m_if.mdata_valid);
        end
    endtask

    task automatic test_fifo_full();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            set_cmd(PZCOREBUS_WRITE, 64'(i * 8), 8'd2);
            #1;
            checks++;
            if (m_if.mcmd_valid !== 1'b1 || s_if.scmd_accept !== 1'b1) begin
                failures++;
                $display("FAIL fill%0d v=%b a=%b exp 1/1",
                         i, m_if.mcmd_valid, s_if.scmd_accept);
            end
        end
        @(negedge clk);
        set_cmd(PZCOREBUS_WRITE, 64'h40, 8'd2);
        #1;
        checks++;
        if (m_if.mcmd_valid !== 1'b0 || s_if.scmd_accept !== 1'b0) begin
            failures++;
            $display("FAIL full_block v=%b a=%b exp 0/0",
                     m_if.mcmd_valid, s_if.scmd_accept);
        end
        s_if.mcmd = PZCOREBUS_READ;
        #1;
        checks++;
        if (m_if.mcmd_valid !== 1'b1 || s_if.scmd_accept !== 1'b1) begin
            failures++;
            $display("FAIL full_read v=%b a=%b exp 1/1",
                     m_if.mcmd_valid, s_if.scmd_accept);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) begin
                set_cmd(PZCOREBUS_WRITE, 64'h40, 8'd2);
            end else begin
                s_if.mcmd_valid = 1'b0;
            end
            set_data(30 + i, 1'b1);
            #1;
            if (i == 0) begin
                checks++;
                if (m_if.mcmd_valid !== 1'b0 || s_if.scmd_accept !== 1'b0) begin
                    failures++;
                    $display("FAIL pop_no_unblock v=%b a=%b exp 0/0",
                             m_if.mcmd_valid, s_if.scmd_accept);
                end
            end
            checks++;
            if (m_if.mdata_valid !== 1'b1 || m_if.mdata !== slice(30 + i, i) ||
                m_if.mdata_last !== 1'b1 || s_if.sdata_accept !== 1'b1) begin
                failures++;
                $display("FAIL drain%0d v=%b d=%h last=%b acc=%b exp d=%h",
                         i, m_if.mdata_valid, m_if.mdata, m_if.mdata_last,
                         s_if.sdata_accept, slice(30 + i, i));
            end
        end
        @(negedge clk);
        s_if.mcmd_valid = 1'b0;
        set_data(39, 1'b1);
        #1;
        checks++;
        if (m_if.mdata_valid !== 1'b0 || s_if.sdata_accept !== 1'b0) begin
            failures++;
            $display("FAIL drained v=%b acc=%b exp 0/0",
                     m_if.mdata_valid, s_if.sdata_accept);
        end
        idle_inputs();
    endtask

    task automatic test_protocol_error();
        int slc [5];
        slc = '{0, 1, 2, 3, 0};
        @(negedge clk);
        set_cmd(PZCOREBUS_WRITE, 64'h0, 8'd9);
        for (int i = 0; i < 5; i++) begin
            int sb;
            sb = (i < 4) ? 0 : 1;
            @(negedge clk);
            s_if.mcmd_valid = 1'b0;
            set_data(60 + sb, 1'b1);
            #1;
            checks++;
            if (m_if.mdata_valid !== 1'b1 ||
                m_if.mdata !== slice(60 + sb, slc[i]) ||
                m_if.mdata_last !== (i == 4) ||
                s_if.sdata_accept !== (i >= 3)) begin
                failures++;
                $display("FAIL perr_beat%0d v=%b d=%h last=%b acc=%b exp %h",
                         i, m_if.mdata_valid, m_if.mdata, m_if.mdata_last,
                         s_if.sdata_accept, slice(60 + sb, slc[i]));
            end
            checks++;
            if (prot_err !== (i == 4)) begin
                failures++;
                $display("FAIL perr_flag%0d got=%b exp=%b",
                         i, prot_err, i == 4);
            end
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (prot_err !== 1'b0 || m_if.mdata_valid !== 1'b0) begin
            failures++;
            $display("FAIL perr_pulse err=%b v=%b exp 0/0",
                     prot_err, m_if.mdata_valid);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [63:0] addrs [3];
        logic [7:0]  lens [3];
        addrs = '{64'h0, 64'h8, 64'h10};
        lens  = '{8'd8, 8'd2, 8'd2};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_cmd(PZCOREBUS_WRITE, addrs[i], lens[i]);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            s_if.mcmd_valid = 1'b0;
            set_data(40, 1'b0);
            #1;
            checks++;
            if (m_if.mdata_valid !== 1'b1 || m_if.mdata !== slice(40, i)) begin
                failures++;
                $display("FAIL mid_beat%0d v=%b d=%h exp %h",
                         i, m_if.mdata_valid, m_if.mdata, slice(40, i));
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (m_if.mdata_valid !== 1'b0 || s_if.sdata_accept !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset v=%b acc=%b exp 0/0",
                     m_if.mdata_valid, s_if.sdata_accept);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (m_if.mdata_valid !== 1'b0 || prot_err !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_empty v=%b err=%b exp 0/0",
                     m_if.mdata_valid, prot_err);
        end
        @(negedge clk);
        set_cmd(PZCOREBUS_WRITE, 64'h28, 8'd5);
        set_data(50, 1'b1);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                @(negedge clk);
                s_if.mcmd_valid = 1'b0;
            end
            #1;
            checks++;
            if (m_if.mdata_valid !== 1'b1 || m_if.mdata !== slice(50, i + 1) ||
                m_if.mdata_last !== (i == 2) ||
                s_if.sdata_accept !== (i == 2)) begin
                failures++;
                $display("FAIL post_reset_beat%0d v=%b d=%h last=%b acc=%b",
                         i, m_if.mdata_valid, m_if.mdata, m_if.mdata_last,
                         s_if.sdata_accept);
            end
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (prot_err !== 1'b0 || m_if.mdata_valid !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_end err=%b v=%b exp 0/0",
                     prot_err, m_if.mdata_valid);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_bypass();
        test_unaligned();
        test_atomic();
        test_fifo_full();
        test_protocol_error();
        test_reset_mid_burst();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pzcorebus_buffered_downsizer_request_path.md
Name: pzcorebus_buffered_downsizer_request_path

Overview:
- Request-side write-data narrower: converts SLAVE_DATA_WIDTH write beats into RATIO = SLAVE_DATA_WIDTH/MASTER_DATA_WIDTH master beats per slave beat. Handles unaligned start offsets and unit-granular lengths.
- Adds a command-info FIFO so write data may lag its command by up to CMD_FIFO_DEPTH commands.
- Adds same-cycle command/data bypass and a length-vs-last protocol error flag.
- Sits between a wide corebus slave port and a narrow master port inside the downsizer.

Parameters:
- SLAVE_DATA_WIDTH, 256, slave data width, multiple of MASTER_DATA_WIDTH.
- MASTER_DATA_WIDTH, 64, master data width.
- UNIT_DATA_WIDTH, 32, length unit width; MASTER_DATA_WIDTH >= UNIT_DATA_WIDTH.
- ADDRESS_WIDTH, 64, address width.
- LENGTH_WIDTH, 8, unpacked length width in units. Value range is 1..2^LENGTH_WIDTH-1; 0 is illegal.
- CMD_FIFO_DEPTH, 4, outstanding with-data commands whose data has not started (>=2).
- ALIGNED_ACCESS_ONLY, 0, 1 forces offset and initial count to 0.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_mcmd_valid  in  1  slave command valid
- o_scmd_accept  out  1  slave command accept
- i_mcmd  in  3  command type (pzcorebus_command_type)
- i_maddr  in  ADDRESS_WIDTH  address
- i_mlength  in  LENGTH_WIDTH  unpacked length, units
- o_mcmd_valid  out  1  master command valid
- i_scmd_accept  in  1  master command accept
- o_mcmd, o_maddr, o_mlength  out  3/ADDRESS_WIDTH/LENGTH_WIDTH  command pass-through
- i_mdata_valid  in  1  slave data valid
- o_sdata_accept  out  1  slave data accept
- i_mdata  in  SLAVE_DATA_WIDTH  slave data
- i_mdata_byteen  in  SLAVE_DATA_WIDTH/8  slave byte enable
- i_mdata_last  in  1  slave last
- o_mdata_valid  out  1  master data valid
- i_sdata_accept  in  1  master data accept
- o_mdata  out  MASTER_DATA_WIDTH  master data slice
- o_mdata_byteen  out  MASTER_DATA_WIDTH/8  master byte-enable slice
- o_mdata_last  out  1  master last
- o_protocol_error  out  1  one-cycle error pulse

Behaviour:
- Reset/clock: i_rst_n asynchronous, active-low; i_clk clock.
- Derived constants: DATA_SIZE = MASTER_DATA_WIDTH/UNIT_DATA_WIDTH; CW = max(1, clog2(RATIO)); MLSB = clog2(MASTER_DATA_WIDTH)-3; ULSB = clog2(UNIT_DATA_WIDTH)-3.
- Internal length register is LENGTH_WIDTH+1 bits wide.
- Reset state:
  - FIFO empty; state IDLE; length/count registers 0; o_protocol_error 0.
  - All other outputs are combinational from this state.
- Command channel, zero latency:
  - o_mcmd/o_maddr/o_mlength = inputs unchanged.
  - With-data commands: o_mcmd_valid = i_mcmd_valid & !full; o_scmd_accept = i_scmd_accept & !full.
  - Other commands: plain pass-through.
  - full is registered; a pop in the same cycle does not unblock a push.
- Push: on a with-data command handshake, push {init_len, init_cnt}.
  - no_off = ALIGNED_ACCESS_ONLY | atomic | message.
  - init_cnt = no_off ? 0 : i_maddr[MLSB +: CW].
  - init_len = i_mlength + ((no_off | DATA_SIZE==1) ? 0 : i_maddr[ULSB +: clog2(DATA_SIZE)]).
- Data FSM:
  - IDLE: entry source = FIFO head if non-empty, else bypass of the current push (same-cycle command handshake). With no source, o_mdata_valid = 0 and o_sdata_accept = 0.
  - First master handshake in IDLE pops the FIFO (no pop on bypass). If that beat is not final, go to BURST.
  - BURST: use latched len/cnt.
  - Each master handshake: len -= DATA_SIZE; cnt += 1 mod 2^CW.
- Per beat (cur = selected len/cnt):
  - final = cur_len <= DATA_SIZE.
  - o_mdata = i_mdata slice cur_cnt; o_mdata_byteen = i_mdata_byteen slice cur_cnt.
  - o_mdata_valid = i_mdata_valid & source_available.
  - consume = final | cur_cnt == RATIO-1.
  - o_sdata_accept = i_sdata_accept & consume & source_available.
  - o_mdata_last = final, generated internally.
  - Final handshake returns to IDLE. A new burst may start the next cycle with no bubble from FIFO head.
- Error: o_protocol_error pulses the cycle after a consuming handshake where i_mdata_last != final. Data flow is unaffected; the burst still ends on final.
- Reset mid-burst discards all FIFO entries and state.

Decomposition:
- pzcorebus_pkg: pzcorebus_command_type, command-kind enum, is_command_with_data(), is_no_offset_command().
- Sub-module: command-info FIFO built from pzbcm_fifo (width LENGTH_WIDTH+1+CW, depth CMD_FIFO_DEPTH).

Test Plan:
- Defaults (RATIO 4, DATA_SIZE 2): WRITE addr 0x28 len 5 with data in the same cycle (bypass) -> 3 master beats, slices 1,2,3; o_mdata_last on the 3rd; one slave accept, on the 3rd.
- WRITE addr 0x24 len 8, 2 slave beats -> 5 master beats, slices 0,1,2,3,0; slave accepts on beats 4 and 5; last on beat 5.
- ATOMIC addr 0x38 len 2 -> offset ignored; 1 beat, slice 0, last.
- 4 with-data commands without data -> FIFO full; 5th: o_mcmd_valid=0 and o_scmd_accept=0. Then 4 single-beat bursts pop in order, back to back, no bubbles.
- Slave asserts i_mdata_last on 1st beat of a 9-unit burst -> o_protocol_error=1 for exactly one cycle; burst still completes at len<=2.
- Reset asserted mid-BURST with 2 FIFO entries -> next cycle o_mdata_valid=0, FIFO empty, new command proceeds normally.
